nums_rom_arbiter: RTL and testbench
===================================

NUMS_ROM_ARBITER -- requirements
Module: nums_rom_arbiter

Interface
REQ-001 Parameters SHALL be N_REQ (default 6, number of digit requesters); ADDR_W (default 11, ROM address width); DATA_W (default 8, pixel width); ROM_LAT (default 1, ROM read latency in cycles, legal 1..2).
REQ-002 One clock, mclk; reset clr is asynchronous, active-high.
REQ-003 mclk  in  1  system clock (100 MHz); all state SHALL change on its rising edge.
REQ-004 clr  in  1  asynchronous active-high reset.
REQ-005 req  in  N_REQ  per-requester read strobe; one-cycle pulse per requested pixel.
REQ-006 req_addr  in  N_REQ*ADDR_W  flattened per-requester addresses; slot i is bits [i*ADDR_W +: ADDR_W].
REQ-007 rom_addr  out  ADDR_W  registered address to the single shared nums ROM.
REQ-008 rom_data  in  DATA_W  ROM output, valid ROM_LAT cycles after the ROM samples rom_addr.
REQ-009 grant  out  N_REQ  registered one-hot; identifies the requester whose address is on rom_addr this cycle.
REQ-010 rd_data  out  N_REQ*DATA_W  per-requester held pixel, flattened like req_addr.
REQ-011 rd_valid  out  N_REQ  one-cycle pulse when the matching rd_data slot updates.

Function
REQ-012 Each slot SHALL hold a pending flag and a captured address; req[i]=1 SHALL set pending[i] and store req_addr slot i.
REQ-013 A new req[i] while pending[i]=1 SHALL overwrite the stored address; only the latest address is served, with no extra read.
REQ-014 Each cycle, if any slot is pending, the block SHALL grant exactly one slot, chosen round-robin starting at the index after the last granted slot, wrapping N_REQ-1 to 0.
REQ-015 On grant, rom_addr SHALL take the stored address, grant SHALL be one-hot for that slot, and pending SHALL clear on the same edge.
REQ-016 If req[i] arrives in the cycle slot i is granted, the grant SHALL use the old address, and pending[i] SHALL remain set with the new address.
REQ-017 With no slot pending, grant SHALL be 0 and rom_addr SHALL hold its last value.
REQ-018 A tag pipeline (valid bit plus index) of depth 1+ROM_LAT SHALL follow each grant; on exit, rom_data SHALL be written into rd_data slot[index], with rd_valid[index] pulsed for one cycle.
REQ-019 Unserved rd_data slots SHALL hold their value indefinitely.
REQ-020 Latency from req sampled at edge E0 to rd_valid rising SHALL be 2+ROM_LAT edges when uncontended.
REQ-021 The worst-case latency SHALL be 2+ROM_LAT+(N_REQ-1) edges.
REQ-022 Throughput SHALL be one ROM read per cycle, with no bubbles while any slot is pending.
REQ-023 The round-robin pointer SHALL advance only on a grant.

Reset
REQ-024 clr=1 SHALL immediately clear pending, stored addresses, tag pipeline, grant, rd_valid, rd_data and rom_addr to 0, and set the pointer so slot 0 has top priority.
REQ-025 Reads in flight at clr SHALL be discarded, with no rd_valid after release.
REQ-026 The first grant SHALL occur no earlier than the second rising edge after clr deasserts.

Structure
REQ-027 N_REQ, ADDR_W, DATA_W and ROM_LAT defaults, and the tag-record type (valid, index), SHALL live in a shared package nums_pkg.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs: pending vector and pointer; output: one-hot grant), instantiated once.
REQ-029 rom_addr and grant SHALL be registered outputs with no combinational path from req.

Verification
REQ-030 Scenario: single req[2] with addr 0x155, ROM_LAT=1 -> grant=6'b000100 one edge later, rom_addr=0x155, rd_valid[2] exactly 3 edges after req, rd_data slot 2 = ROM[0x155].
REQ-031 Scenario: all six req together (addrs 0x010..0x015) after reset -> grants 0,1,2,3,4,5 on consecutive cycles; rd_valid pulses 3..8 edges after req, each slot holding its own ROM word.
REQ-032 Scenario: after slot 5 served, req[0] and req[5] together -> slot 0 granted first (pointer wrap), slot 5 next cycle.
REQ-033 Scenario: req[1] addr 0x020 then req[1] addr 0x030 next cycle while still pending -> exactly one read at 0x030, exactly one rd_valid[1] pulse.
REQ-034 Scenario: assert clr one cycle after grant of slot 3 -> no rd_valid[3] ever, all outputs 0 during clr, first grant after release comes only from new requests.
REQ-035 Scenario: continuous req[4] every cycle with others idle -> grant[4] every cycle, rd_valid[4] every cycle after a 3-cycle fill.

Source files
------------

// File: rtl/nums_pkg.sv
// Shared defaults and tag record for the nums ROM arbiter.
// Imported by the arbiter top and its round-robin picker.
package nums_pkg;

  localparam int N_REQ_DEF   = 6;
  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 8;
  localparam int ROM_LAT_DEF = 1;

  localparam int IDX_W = $clog2(N_REQ_DEF);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/nums_rom_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending slot at or
// after the pointer, wrapping to slot 0.
module rr_picker
  import nums_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_pending,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 0; off < N; off++) begin
      w_idx = (int'(i_ptr) + off) % N;
      if (!w_found && i_pending[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nums_rom_arbiter.sv
// Shares one nums ROM among N_REQ digit requesters with a
// round-robin grant and a tag pipeline routing data back.
module nums_rom_arbiter
  import nums_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic                    mclk,
  input  logic                    clr,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ*DATA_W-1:0] rd_data,
  output logic [N_REQ-1:0]        rd_valid
);

  localparam int PW    = $clog2(N_REQ);
  localparam int DEPTH = 1 + ROM_LAT;

  logic [N_REQ-1:0]        r_pending;
  logic [ADDR_W-1:0]       r_addr [N_REQ];
  logic [PW-1:0]           r_ptr;
  logic [N_REQ-1:0]        r_grant;
  logic [ADDR_W-1:0]       r_rom_addr;
  tag_t                    r_tag [DEPTH];
  logic [N_REQ*DATA_W-1:0] r_rd_data;
  logic [N_REQ-1:0]        r_rd_valid;

  logic [N_REQ-1:0] w_pick;
  logic [PW-1:0]    w_pick_idx;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_any;

  rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_grant   (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (w_pick[i]) w_pick_idx = PW'(i);
  end

  assign w_any     = |w_pick;
  assign w_ptr_nxt = (w_pick_idx == PW'(N_REQ - 1)) ?
                     '0 : w_pick_idx + PW'(1);

  // A same-cycle req re-arms the slot being granted
  always_ff @(posedge mclk or posedge clr) begin
    if (clr) begin
      r_pending <= '0;
      for (int i = 0; i < N_REQ; i++) r_addr[i] <= '0;
    end else begin
      r_pending <= (r_pending & ~w_pick) | req;
      for (int i = 0; i < N_REQ; i++)
        if (req[i]) r_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge mclk or posedge clr) begin
    if (clr) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_rom_addr <= '0;
    end else begin
      r_grant <= w_pick;
      if (w_any) begin
        r_rom_addr <= r_addr[w_pick_idx];
        r_ptr      <= w_ptr_nxt;
      end
    end
  end

  always_ff @(posedge mclk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_any, idx: IDX_W'(w_pick_idx)};
      for (int k = 1; k < DEPTH; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  always_ff @(posedge mclk or posedge clr) begin
    if (clr) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      r_rd_valid <= '0;
      if (r_tag[DEPTH-1].valid) begin
        r_rd_data[int'(r_tag[DEPTH-1].idx)*DATA_W +: DATA_W]
          <= rom_data;
        r_rd_valid[r_tag[DEPTH-1].idx] <= 1'b1;
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign grant    = r_grant;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_nums_rom_arbiter.sv
// Directed bench for nums_rom_arbiter with a one-cycle
// synchronous ROM model.
module tb_nums_rom_arbiter;

  logic        mclk = 1'b0;
  logic        clr;
  logic [5:0]  req;
  logic [65:0] req_addr;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [5:0]  grant;
  logic [47:0] rd_data;
  logic [5:0]  rd_valid;

  int n_checks = 0;
  int n_pass   = 0;

  nums_rom_arbiter #(
    .N_REQ(6), .ADDR_W(11), .DATA_W(8), .ROM_LAT(1)
  ) dut (
    .mclk     (mclk),
    .clr      (clr),
    .req      (req),
    .req_addr (req_addr),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .grant    (grant),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 mclk = ~mclk;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h5A;
  endfunction

  always @(posedge mclk) rom_data <= rom_fn(rom_addr);

  function automatic logic [7:0] slot(input logic [47:0] v,
                                      input int i);
    return v[i*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [10:0] a);
    req_addr[i*11 +: 11] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1;
    req = '0;
    req_addr = '0;
    tick;
    tick;
    chk("rst_grant", grant, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    clr = 1'b0;

    // single req[2] at 0x155
    req = 6'b000100;
    set_addr(2, 11'h155);
    tick;
    req = '0;
    chk("s1_e0_grant", grant, 0);
    tick;
    chk("s1_e1_grant", grant, 6'b000100);
    chk("s1_e1_addr", rom_addr, 11'h155);
    chk("s1_e1_valid", rd_valid, 0);
    tick;
    chk("s1_e2_grant", grant, 0);
    chk("s1_e2_addr_hold", rom_addr, 11'h155);
    chk("s1_e2_valid", rd_valid, 0);
    tick;
    chk("s1_e3_valid", rd_valid, 6'b000100);
    chk("s1_e3_data", slot(rd_data, 2), rom_fn(11'h155));
    tick;
    chk("s1_e4_valid", rd_valid, 0);
    chk("s1_e4_hold", slot(rd_data, 2), rom_fn(11'h155));

    // all six together after reset
    clr = 1'b1;
    tick;
    clr = 1'b0;
    req = 6'h3F;
    for (int i = 0; i < 6; i++) set_addr(i, 11'h010 + 11'(i));
    tick;
    req = '0;
    for (int n = 1; n <= 9; n++) begin
      tick;
      chk($sformatf("s2_grant_e%0d", n), grant,
          (n <= 6) ? 64'(6'b1 << (n-1)) : 64'd0);
      if (n <= 6)
        chk($sformatf("s2_addr_e%0d", n), rom_addr,
            64'(11'h010 + 11'(n-1)));
      chk($sformatf("s2_valid_e%0d", n), rd_valid,
          (n >= 3 && n <= 8) ? 64'(6'b1 << (n-3)) : 64'd0);
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("s2_data%0d", i), slot(rd_data, i),
          rom_fn(11'h010 + 11'(i)));

    // pointer wrap: slot 0 before slot 5
    req = 6'b100001;
    set_addr(0, 11'h0A0);
    set_addr(5, 11'h0A5);
    tick;
    req = '0;
    tick;
    chk("s3_e1_grant", grant, 6'b000001);
    chk("s3_e1_addr", rom_addr, 11'h0A0);
    tick;
    chk("s3_e2_grant", grant, 6'b100000);
    chk("s3_e2_addr", rom_addr, 11'h0A5);
    tick;
    chk("s3_e3_valid", rd_valid, 6'b000001);
    chk("s3_e3_data", slot(rd_data, 0), rom_fn(11'h0A0));
    tick;
    chk("s3_e4_valid", rd_valid, 6'b100000);
    chk("s3_e4_data", slot(rd_data, 5), rom_fn(11'h0A5));

    // overwrite while still pending behind slot 0
    req = 6'b000011;
    set_addr(0, 11'h0B0);
    set_addr(1, 11'h020);
    tick;
    req = 6'b000010;
    set_addr(1, 11'h030);
    tick;
    req = '0;
    chk("s4_e1_grant", grant, 6'b000001);
    chk("s4_e1_addr", rom_addr, 11'h0B0);
    tick;
    chk("s4_e2_grant", grant, 6'b000010);
    chk("s4_e2_addr", rom_addr, 11'h030);
    tick;
    chk("s4_e3_grant", grant, 0);
    chk("s4_e3_valid", rd_valid, 6'b000001);
    tick;
    chk("s4_e4_valid", rd_valid, 6'b000010);
    chk("s4_e4_data", slot(rd_data, 1), rom_fn(11'h030));
    tick;
    chk("s4_e5_valid", rd_valid, 0);
    tick;
    chk("s4_e6_valid", rd_valid, 0);

    // req in the grant cycle: old address first, then new
    req = 6'b001000;
    set_addr(3, 11'h040);
    tick;
    set_addr(3, 11'h041);
    tick;
    req = '0;
    chk("s5_e1_grant", grant, 6'b001000);
    chk("s5_e1_addr", rom_addr, 11'h040);
    tick;
    chk("s5_e2_grant", grant, 6'b001000);
    chk("s5_e2_addr", rom_addr, 11'h041);
    tick;
    chk("s5_e3_grant", grant, 0);
    chk("s5_e3_data", slot(rd_data, 3), rom_fn(11'h040));
    tick;
    chk("s5_e4_valid", rd_valid, 6'b001000);
    chk("s5_e4_data", slot(rd_data, 3), rom_fn(11'h041));

    // clr right after grant of slot 3
    req = 6'b001000;
    set_addr(3, 11'h063);
    tick;
    req = '0;
    tick;
    chk("s6_grant3", grant, 6'b001000);
    clr = 1'b1;
    #1;
    chk("s6_clr_grant", grant, 0);
    chk("s6_clr_addr", rom_addr, 0);
    chk("s6_clr_valid", rd_valid, 0);
    chk("s6_clr_data", rd_data, 0);
    tick;
    chk("s6_clr2_grant", grant, 0);
    chk("s6_clr2_valid", rd_valid, 0);
    clr = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick;
      chk($sformatf("s6_idle_valid%0d", n), rd_valid, 0);
      chk($sformatf("s6_idle_grant%0d", n), grant, 0);
    end
    req = 6'b000010;
    set_addr(1, 11'h070);
    tick;
    req = '0;
    tick;
    chk("s6_new_grant", grant, 6'b000010);
    chk("s6_new_addr", rom_addr, 11'h070);
    tick;
    tick;
    chk("s6_new_valid", rd_valid, 6'b000010);
    chk("s6_new_data", slot(rd_data, 1), rom_fn(11'h070));
    tick;

    // continuous req[4]
    for (int n = 0; n < 10; n++) begin
      if (n < 8) begin
        req = 6'b010000;
        set_addr(4, 11'h100 + 11'(n));
      end else begin
        req = '0;
      end
      tick;
      chk($sformatf("s7_grant%0d", n), grant,
          (n >= 1 && n <= 8) ? 64'h10 : 64'h0);
      if (n >= 1 && n <= 8)
        chk($sformatf("s7_addr%0d", n), rom_addr,
            64'(11'h100 + 11'(n-1)));
      chk($sformatf("s7_valid%0d", n), rd_valid,
          (n >= 3) ? 64'h10 : 64'h0);
      if (n >= 3)
        chk($sformatf("s7_data%0d", n), slot(rd_data, 4),
            rom_fn(11'h100 + 11'(n-3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
